// File: rtl/md_sequencer.sv
// md_sequencer: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO pair.
// Magnitudes are computed unsigned over WIDTH cycles and the sign is fixed on commit.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_a, mag_b, raw_a;
  logic               neg_q, rem_neg;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;

  // md_op[0] clear means a signed op; md_op[1] set means a divide
  logic             in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign in_signed = ~md_op[0];
  assign abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add step: add the multiplicand into the upper half when the low bit is set, then shift right
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Restoring step: upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q   ? -acc : acc;
  assign quo_fix  = neg_q   ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> CALC on start, WIDTH iterations, one commit cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result commit and MTHI/MTLO writes
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      op_q     <= 2'b00;
      mag_a    <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      neg_q    <= 1'b0;
      rem_neg  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q    <= md_op;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            raw_a   <= a;
            neg_q   <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg <= in_signed & a[WIDTH-1];
            cnt     <= '0;
            acc     <= md_op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          end
        end
        CALC: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          done <= 1'b1;
          if (!op_q[1]) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (mag_b == '0) begin
            hi       <= raw_a;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi       <= rem_fix;
            lo       <= quo_fix;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed vector table, hand-written
// corner sequences and randomized operations against an arithmetic reference model.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  md_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one value and log a FAIL line on disagreement
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: results straight from 64-bit signed/unsigned math
  function automatic void refModel(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] rh, output logic [31:0] rl);
    logic signed [63:0] sa, sb, p;
    logic [63:0] u;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    rh = '0;
    rl = '0;
    case (op)
      2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin u = {32'b0, av} * {32'b0, bv}; rh = u[63:32]; rl = u[31:0]; end
      default: begin
        if (bv == 32'd0) begin
          rh = av;
          rl = 32'hFFFFFFFF;
        end else if (op == 2'b10) begin
          p = sa / sb; rl = p[31:0];
          p = sa % sb; rh = p[31:0];
        end else begin
          rl = av / bv;
          rh = av % bv;
        end
      end
    endcase
  endfunction

  // Issue a start in IDLE (optionally with a same-cycle MTLO), then scramble operands
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                               input logic wlo, input logic [31:0] wd);
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv; lo_we = wlo; wdata = wd;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Count busy cycles (bounded); optionally inject a start+writes and sample HI/LO mid-run
  task automatic waitDone(input int inject_at, output int cycles, output bit overlap,
                          output logic [31:0] hi_mid, output logic [31:0] lo_mid);
    cycles = 0; overlap = 1'b0; hi_mid = '0; lo_mid = '0;
    while (busy && cycles < 100) begin
      if (done) overlap = 1'b1;
      if (cycles == inject_at + 2) begin hi_mid = hi; lo_mid = lo; end
      if (cycles == inject_at) begin
        start = 1'b1; md_op = 2'b11; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD0000;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Run one operation and check latency, done pulse and committed results
  task automatic runAndCheck(input string name, input logic [1:0] op, input logic [31:0] av,
                             input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                             input logic edz);
    int cycles;
    bit overlap;
    logic [31:0] hm, lm;
    applyStimulus(op, av, bv, 1'b0, 32'h0);
    waitDone(-10, cycles, overlap, hm, lm);
    checkOutput({name, " busy_cycles"}, cycles, 33);
    checkOutput({name, " busy_done_overlap"}, {31'b0, overlap}, 0);
    checkOutput({name, " done_pulse"}, {31'b0, done}, 1);
    checkOutput({name, " hi"}, hi, eh);
    checkOutput({name, " lo"}, lo, el);
    checkOutput({name, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    @(negedge clk);
    checkOutput({name, " done_after"}, {31'b0, done}, 0);
    checkOutput({name, " busy_after"}, {31'b0, busy}, 0);
  endtask

  initial begin
    int cycles;
    bit overlap;
    logic [31:0] hm, lm, eh, el;
    logic [1:0] op;
    logic [31:0] av, bv;
    logic dz_model;

    vecs[0] = '{op:2'b01, a:32'hFFFFFFFF, b:32'hFFFFFFFF, hi:32'hFFFFFFFE, lo:32'h00000001, dz:1'b0};
    vecs[1] = '{op:2'b00, a:32'hFFFFFFFD, b:32'h00000005, hi:32'hFFFFFFFF, lo:32'hFFFFFFF1, dz:1'b0};
    vecs[2] = '{op:2'b10, a:32'hFFFFFFF9, b:32'h00000002, hi:32'hFFFFFFFF, lo:32'hFFFFFFFD, dz:1'b0};
    vecs[3] = '{op:2'b10, a:32'h80000000, b:32'hFFFFFFFF, hi:32'h00000000, lo:32'h80000000, dz:1'b0};
    vecs[4] = '{op:2'b11, a:32'h00000009, b:32'h00000000, hi:32'h00000009, lo:32'hFFFFFFFF, dz:1'b1};
    vecs[5] = '{op:2'b01, a:32'h00000002, b:32'h00000003, hi:32'h00000000, lo:32'h00000006, dz:1'b1};
    vecs[6] = '{op:2'b11, a:32'h00000009, b:32'h00000002, hi:32'h00000001, lo:32'h00000004, dz:1'b0};
    vecs[7] = '{op:2'b10, a:32'h00000007, b:32'hFFFFFFFE, hi:32'h00000001, lo:32'hFFFFFFFD, dz:1'b0};
    vecs[8] = '{op:2'b10, a:32'hFFFFFFF8, b:32'h00000000, hi:32'hFFFFFFF8, lo:32'hFFFFFFFF, dz:1'b1};

    rst = 1'b1; start = 1'b0; md_op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset hi", hi, 0);
    checkOutput("reset lo", lo, 0);
    checkOutput("reset busy", {31'b0, busy}, 0);
    checkOutput("reset done", {31'b0, done}, 0);
    checkOutput("reset div_zero", {31'b0, div_zero}, 0);

    // Directed vector table
    for (int i = 0; i < 9; i++)
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // Reset asserted during the 10th CALC cycle aborts everything
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'h12345678, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset hi", hi, 0);
    checkOutput("midreset lo", lo, 0);
    checkOutput("midreset busy", {31'b0, busy}, 0);
    checkOutput("midreset done", {31'b0, done}, 0);
    checkOutput("midreset div_zero", {31'b0, div_zero}, 0);
    runAndCheck("fresh_multu", 2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);

    // MTHI in IDLE, then MULTU with same-cycle MTLO, then ignored start/writes mid-CALC
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi hi", hi, 32'h00001234);
    applyStimulus(2'b01, 32'd2, 32'd3, 1'b1, 32'h00005555);
    checkOutput("start_mtlo lo", lo, 32'h00005555);
    waitDone(4, cycles, overlap, hm, lm);
    checkOutput("busy_writes hi_mid", hm, 32'h00001234);
    checkOutput("busy_writes lo_mid", lm, 32'h00005555);
    checkOutput("busy_writes busy_cycles", cycles, 33);
    checkOutput("busy_writes hi", hi, 0);
    checkOutput("busy_writes lo", lo, 6);
    checkOutput("busy_writes div_zero", {31'b0, div_zero}, 0);
    @(negedge clk);
    checkOutput("ignored_start busy", {31'b0, busy}, 0);

    // Randomized operations against the reference model
    dz_model = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'd0;
        1: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
        2: begin av = 32'($urandom_range(0, 100)); bv = 32'($urandom_range(1, 9)); end
        3: bv = {16'hFFFF, bv[15:0]};
        default: ;
      endcase
      refModel(op, av, bv, eh, el);
      if (op[1]) dz_model = (bv == 32'd0);
      runAndCheck($sformatf("rand%0d", i), op, av, bv, eh, el, dz_model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
